// File: rtl/rf_pkg.sv
// Shared register-file definitions for the write-back slice.
package rf_pkg;

  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned REG_W    = 32;
  localparam int unsigned RO_REGS  = 3;

  typedef logic [4:0] reg_idx_t;

  typedef struct packed {
    reg_idx_t          rd;
    logic [REG_W-1:0]  data;
  } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Small FIFO of write-back requests; no bypass, simultaneous push/pop allowed.
module wb_fifo
  import rf_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter type         T     = wb_req_t
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           push,
  input  T                               push_data,
  input  logic                           pop,
  output T                               head,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  T              r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  logic w_push;
  logic w_pop;

  assign full   = (r_count == CW'(DEPTH));
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign head   = r_mem[r_rptr];
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= push_data;
  end

endmodule

// File: rtl/rf_writeback_arb.sv
// Register-file write-port owner: arbitrates ALU results against queued
// load responses, registers the write strobe and tracks pending loads.
module rf_writeback_arb
  import rf_pkg::*;
#(
  parameter int unsigned DATA_W   = REG_W,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned LQ_DEPTH = 2,
  parameter int unsigned RO_REGS  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [ADDR_W-1:0]     alu_rd,
  input  logic [DATA_W-1:0]     alu_data,
  input  logic                  ld_issue_valid,
  input  logic [ADDR_W-1:0]     ld_issue_rd,
  input  logic                  ld_resp_valid,
  output logic                  ld_resp_ready,
  input  logic [ADDR_W-1:0]     ld_resp_rd,
  input  logic [DATA_W-1:0]     ld_resp_data,
  output logic                  rf_write_enable,
  output logic [ADDR_W-1:0]     rf_write_reg,
  output logic [DATA_W-1:0]     rf_write_data,
  output logic [2**ADDR_W-1:0]  busy_mask
);

  localparam int unsigned NREGS = 2**ADDR_W;
  localparam int unsigned CW    = $clog2(LQ_DEPTH + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } req_t;

  req_t              w_push_req;
  req_t              w_head;
  logic              w_full;
  logic              w_empty;
  logic [CW-1:0]     w_count;
  logic              w_push;
  logic              w_pop;
  logic              w_alu_win;
  logic              w_win;
  logic [ADDR_W-1:0] w_sel_rd;
  logic [DATA_W-1:0] w_sel_data;
  logic              w_wr_ok;
  logic [NREGS-1:0]  w_busy_nxt;

  logic              r_we;
  logic [ADDR_W-1:0] r_wreg;
  logic [DATA_W-1:0] r_wdata;
  logic [NREGS-1:0]  r_busy;

  assign w_push_req.rd   = ld_resp_rd;
  assign w_push_req.data = ld_resp_data;

  assign alu_ready     = !w_full;
  assign ld_resp_ready = !w_full;
  assign w_push        = ld_resp_valid && !w_full;

  wb_fifo #(
    .DEPTH (LQ_DEPTH),
    .T     (req_t)
  ) u_lq (
    .clk       (clk),
    .reset     (reset),
    .push      (w_push),
    .push_data (w_push_req),
    .pop       (w_pop),
    .head      (w_head),
    .full      (w_full),
    .empty     (w_empty),
    .count     (w_count)
  );

  // A full queue always drains first so the ALU stalls for one cycle at most.
  always_comb begin
    w_pop      = 1'b0;
    w_alu_win  = 1'b0;
    w_sel_rd   = '0;
    w_sel_data = '0;
    if (w_full) begin
      w_pop      = 1'b1;
      w_sel_rd   = w_head.rd;
      w_sel_data = w_head.data;
    end else if (alu_valid) begin
      w_alu_win  = 1'b1;
      w_sel_rd   = alu_rd;
      w_sel_data = alu_data;
    end else if (!w_empty) begin
      w_pop      = 1'b1;
      w_sel_rd   = w_head.rd;
      w_sel_data = w_head.data;
    end
  end

  assign w_win   = w_pop || w_alu_win;
  assign w_wr_ok = (w_sel_rd >= ADDR_W'(RO_REGS));

  // Clear before set so a same-cycle issue to the popped register stays pending.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_pop) w_busy_nxt[w_head.rd] = 1'b0;
    if (ld_issue_valid) w_busy_nxt[ld_issue_rd] = 1'b1;
    for (int unsigned i = 0; i < RO_REGS; i++) w_busy_nxt[i] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_we    <= 1'b0;
      r_wreg  <= '0;
      r_wdata <= '0;
      r_busy  <= '0;
    end else begin
      r_we   <= w_win && w_wr_ok;
      r_busy <= w_busy_nxt;
      if (w_win && w_wr_ok) begin
        r_wreg  <= w_sel_rd;
        r_wdata <= w_sel_data;
      end
    end
  end

  assign rf_write_enable = r_we;
  assign rf_write_reg    = r_wreg;
  assign rf_write_data   = r_wdata;
  assign busy_mask       = r_busy;

  logic w_unused;
  assign w_unused = ^w_count;

endmodule
